// File: rtl/extclk_change_monitor.sv
// extclk_change_monitor: captures a reference external-clock frequency and
// raises a sticky flag once later measurements have deviated from it by more
// than the programmed limit for pCONFIRM consecutive samples. The whole block
// runs in the clk_usb domain.
module extclk_change_monitor #(
  parameter int pDISCARD = 1,
  parameter int pCONFIRM = 2
) (
  input  logic        clk_usb,
  input  logic        reset_n,
  input  logic [31:0] extclk_frequency,
  input  logic        freq_valid,
  input  logic        extclk_monitor_disabled,
  input  logic [31:0] extclk_limit,
  input  logic        extclk_change_clear,
  output logic        extclk_change,
  output logic [31:0] ref_frequency,
  output logic [1:0]  monitor_state
);

  // Discard counter only has to hold pDISCARD; keep at least one bit.
  localparam int DW = (pDISCARD < 1) ? 1 : $clog2(pDISCARD + 1);
  localparam logic [DW-1:0] DISCARD_LOAD = DW'(pDISCARD);
  localparam logic [3:0]    CONFIRM_TRIP = 4'(pCONFIRM);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_MONITOR  = 2'd2,
    ST_TRIPPED  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          change_q, change_d;
  logic [31:0]   ref_q, ref_d;
  logic [DW-1:0] discard_q, discard_d;
  logic [3:0]    confirm_q, confirm_d;

  logic [31:0]   diff;
  logic          out_of_limit;
  logic [3:0]    confirm_inc;

  // Absolute deviation: subtract the smaller operand from the larger so the
  // result never wraps, then compare strictly against the live limit.
  always_comb begin
    if (extclk_frequency >= ref_q) diff = extclk_frequency - ref_q;
    else                           diff = ref_q - extclk_frequency;
    out_of_limit = (diff > extclk_limit);
    confirm_inc  = (confirm_q == 4'd15) ? confirm_q : confirm_q + 4'd1;
  end

  // Next-state and register updates; disable overrides every other event.
  always_comb begin
    state_d   = state_q;
    change_d  = change_q;
    ref_d     = ref_q;
    discard_d = discard_q;
    confirm_d = confirm_q;
    if (extclk_monitor_disabled) begin
      state_d   = ST_DISABLED;
      change_d  = 1'b0;
      discard_d = '0;
      confirm_d = '0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d   = ST_ACQUIRE;
          discard_d = DISCARD_LOAD;
        end
        ST_ACQUIRE: begin
          if (extclk_change_clear) begin
            discard_d = DISCARD_LOAD;
          end else if (freq_valid) begin
            if (discard_q != '0) begin
              discard_d = discard_q - 1'b1;
            end else begin
              ref_d     = extclk_frequency;
              confirm_d = '0;
              state_d   = ST_MONITOR;
            end
          end
        end
        ST_MONITOR: begin
          if (extclk_change_clear) begin
            confirm_d = '0;
            discard_d = DISCARD_LOAD;
            state_d   = ST_ACQUIRE;
          end else if (freq_valid) begin
            if (out_of_limit) begin
              confirm_d = confirm_inc;
              if (confirm_inc >= CONFIRM_TRIP) begin
                state_d  = ST_TRIPPED;
                change_d = 1'b1;
              end
            end else begin
              confirm_d = '0;
            end
          end
        end
        ST_TRIPPED: begin
          change_d = 1'b1;
          if (extclk_change_clear) begin
            change_d  = 1'b0;
            confirm_d = '0;
            discard_d = DISCARD_LOAD;
            state_d   = ST_ACQUIRE;
          end
        end
        default: begin
          state_d = ST_DISABLED;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_DISABLED;
      change_q  <= 1'b0;
      ref_q     <= '0;
      discard_q <= '0;
      confirm_q <= '0;
    end else begin
      state_q   <= state_d;
      change_q  <= change_d;
      ref_q     <= ref_d;
      discard_q <= discard_d;
      confirm_q <= confirm_d;
    end
  end

  assign extclk_change = change_q;
  assign ref_frequency = ref_q;
  assign monitor_state = state_q;

endmodule

// File: tb/tb_extclk_change_monitor.sv
// Directed testbench for extclk_change_monitor (pDISCARD=1, pCONFIRM=2).
module tb_extclk_change_monitor;

  logic        clk_usb;
  logic        reset_n;
  logic [31:0] extclk_frequency;
  logic        freq_valid;
  logic        extclk_monitor_disabled;
  logic [31:0] extclk_limit;
  logic        extclk_change_clear;
  logic        extclk_change;
  logic [31:0] ref_frequency;
  logic [1:0]  monitor_state;

  int n_checks = 0;
  int n_errors = 0;

  extclk_change_monitor #(.pDISCARD(1), .pCONFIRM(2)) dut (
    .clk_usb                 (clk_usb),
    .reset_n                 (reset_n),
    .extclk_frequency        (extclk_frequency),
    .freq_valid              (freq_valid),
    .extclk_monitor_disabled (extclk_monitor_disabled),
    .extclk_limit            (extclk_limit),
    .extclk_change_clear     (extclk_change_clear),
    .extclk_change           (extclk_change),
    .ref_frequency           (ref_frequency),
    .monitor_state           (monitor_state)
  );

  // Clock: 10 ns period, active edge is posedge.
  initial clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One freq_valid strobe; returns on the following negedge.
  task automatic sample(input logic [31:0] f);
    @(negedge clk_usb);
    extclk_frequency = f;
    freq_valid = 1'b1;
    @(negedge clk_usb);
    freq_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk_usb);
    extclk_change_clear = 1'b1;
    @(negedge clk_usb);
    extclk_change_clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    extclk_frequency = '0;
    freq_valid = 1'b0;
    extclk_monitor_disabled = 1'b1;
    extclk_limit = 32'd9;
    extclk_change_clear = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk_usb);
    check("rst_state", monitor_state, 0);
    check("rst_change", extclk_change, 0);
    check("rst_ref", ref_frequency, 0);
    reset_n = 1'b1;
    @(negedge clk_usb);
    check("disabled_hold", monitor_state, 0);
    extclk_monitor_disabled = 1'b0;
    @(negedge clk_usb);
    check("enable_acquire", monitor_state, 1);

    // Acquire and trip: limit 9.
    sample(500);
    check("acq_discard_state", monitor_state, 1);
    check("acq_discard_ref", ref_frequency, 0);
    sample(1000);
    check("acq_ref", ref_frequency, 1000);
    check("acq_monitor", monitor_state, 2);
    sample(1005);
    check("s1005_change", extclk_change, 0);
    sample(1010);
    check("s1010_change", extclk_change, 0);
    check("s1010_confirm", dut.confirm_q, 1);
    sample(1011);
    check("s1011_change", extclk_change, 1);
    check("s1011_state", monitor_state, 3);
    sample(1012);
    check("tripped_hold_state", monitor_state, 3);
    check("tripped_hold_ref", ref_frequency, 1000);

    // Boundary and confirm reset, ref re-acquired at 1000.
    clear_pulse();
    check("clr1_change", extclk_change, 0);
    check("clr1_state", monitor_state, 1);
    sample(777);
    sample(1000);
    check("bnd_ref", ref_frequency, 1000);
    sample(1009);
    check("bnd_1009_confirm", dut.confirm_q, 0);
    sample(991);
    check("bnd_991_confirm", dut.confirm_q, 0);
    sample(1020);
    check("bnd_1020_confirm", dut.confirm_q, 1);
    sample(1000);
    check("bnd_1000_confirm", dut.confirm_q, 0);
    sample(1020);
    check("bnd_no_trip_change", extclk_change, 0);
    check("bnd_no_trip_state", monitor_state, 2);

    // Clear strobe in MONITOR returns to ACQUIRE.
    clear_pulse();
    check("mon_clear_state", monitor_state, 1);
    check("mon_clear_confirm", dut.confirm_q, 0);

    // Absolute-value path: ref 16, samples 0 with limit 15 -> trip.
    sample(1);
    sample(32'h10);
    check("abs_ref", ref_frequency, 32'h10);
    extclk_limit = 32'd15;
    sample(0);
    check("abs15_first_state", monitor_state, 2);
    sample(0);
    check("abs15_change", extclk_change, 1);
    check("abs15_state", monitor_state, 3);
    clear_pulse();
    sample(1);
    sample(32'h10);
    extclk_limit = 32'd16;
    sample(0);
    sample(0);
    check("abs16_change", extclk_change, 0);
    check("abs16_state", monitor_state, 2);

    // Zero-reference case: ref 0 then nonzero clock trips.
    clear_pulse();
    sample(5);
    sample(0);
    check("zero_ref", ref_frequency, 0);
    sample(100);
    sample(100);
    check("zero_ref_trip", extclk_change, 1);

    // Disable priority over clear and freq_valid while TRIPPED.
    @(negedge clk_usb);
    extclk_monitor_disabled = 1'b1;
    extclk_change_clear = 1'b1;
    freq_valid = 1'b1;
    extclk_frequency = 32'd5;
    @(negedge clk_usb);
    extclk_change_clear = 1'b0;
    freq_valid = 1'b0;
    check("dis_state", monitor_state, 0);
    check("dis_change", extclk_change, 0);
    check("dis_ref_hold", ref_frequency, 0);
    extclk_monitor_disabled = 1'b0;
    @(negedge clk_usb);
    check("reenable_state", monitor_state, 1);

    // Clear re-arm: trip, clear, then 2000, 2000, 2100.
    sample(50);
    sample(16);
    sample(200);
    sample(200);
    check("rearm_tripped", monitor_state, 3);
    clear_pulse();
    check("rearm_clear_change", extclk_change, 0);
    check("rearm_clear_state", monitor_state, 1);
    sample(2000);
    check("rearm_discard_ref", ref_frequency, 16);
    sample(2000);
    check("rearm_ref", ref_frequency, 2000);
    sample(2100);
    check("rearm_confirm", dut.confirm_q, 1);
    check("rearm_no_trip", extclk_change, 0);
    check("rearm_state", monitor_state, 2);

    // Asynchronous reset mid-cycle while in MONITOR.
    @(posedge clk_usb);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", monitor_state, 0);
    check("arst_ref", ref_frequency, 0);
    check("arst_change", extclk_change, 0);
    @(negedge clk_usb);
    reset_n = 1'b1;
    @(negedge clk_usb);
    check("arst_release_state", monitor_state, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
